// File: rtl/regfile_bypass_pkg.sv
// regfile_bypass_pkg: shared sizes and bypass select encoding for the register file
package regfile_bypass_pkg;
  localparam int N = 16;
  localparam int R = 8;
  localparam int SEL_W = $clog2(R);
  typedef enum logic {BYP_STORED = 1'b0, BYP_WRITE = 1'b1} byp_sel_e;
endpackage

// File: rtl/regfile_bypass_rf_core.sv
// rf_core: un-bypassed register file, one synchronous write port and two async read ports
module rf_core
  import regfile_bypass_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [SEL_W-1:0] wsel,
  input  logic [N-1:0]     wdata,
  input  logic [SEL_W-1:0] rsel1,
  input  logic [SEL_W-1:0] rsel2,
  output logic [N-1:0]     rdata1,
  output logic [N-1:0]     rdata2
);
  logic [N-1:0] regs [R];
  always_ff @(posedge clk)
    if (rst) regs <= '{default: '0};
    else if (we) regs[wsel] <= wdata;
  assign rdata1 = regs[rsel1];
  assign rdata2 = regs[rsel2];
endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass: register file with same-cycle write-to-read bypass on both read ports
module regfile_bypass
  import regfile_bypass_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] read1RegSel,
  input  logic [SEL_W-1:0] read2RegSel,
  input  logic [SEL_W-1:0] writeRegSel,
  input  logic [N-1:0]     writeData,
  input  logic             writeEn,
  output logic [N-1:0]     read1Data,
  output logic [N-1:0]     read2Data,
  output logic             err
);
  logic [N-1:0] stored1, stored2;
  byp_sel_e sel1, sel2;
  rf_core u_core (
    .clk(clk), .rst(rst), .we(writeEn), .wsel(writeRegSel), .wdata(writeData),
    .rsel1(read1RegSel), .rsel2(read2RegSel), .rdata1(stored1), .rdata2(stored2)
  );
  // bypass is suppressed under reset so reads never show data that will be dropped
  always_comb begin
    sel1 = (writeEn && !rst && read1RegSel == writeRegSel) ? BYP_WRITE : BYP_STORED;
    sel2 = (writeEn && !rst && read2RegSel == writeRegSel) ? BYP_WRITE : BYP_STORED;
    read1Data = (sel1 == BYP_WRITE) ? writeData : stored1;
    read2Data = (sel2 == BYP_WRITE) ? writeData : stored2;
  end
  assign err = $isunknown({writeEn, rst, writeRegSel, read1RegSel, read2RegSel});
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: table-driven and model-driven scoreboard bench for regfile_bypass
module tb_regfile_bypass;
  import regfile_bypass_pkg::*;
  logic clk = 1'b0;
  logic rst, we;
  logic [SEL_W-1:0] r1, r2, ws;
  logic [N-1:0] wd, d1, d2;
  logic err;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic rst, we;
    logic [2:0] ws;
    logic [15:0] wd;
    logic [2:0] r1, r2;
    logic chk;
    logic [15:0] e1, e2;
  } vec_t;
  typedef struct {
    logic chk;
    logic [15:0] e1, e2;
    logic e_err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  logic [15:0] mem [8];

  regfile_bypass dut (
    .clk(clk), .rst(rst), .read1RegSel(r1), .read2RegSel(r2), .writeRegSel(ws),
    .writeData(wd), .writeEn(we), .read1Data(d1), .read2Data(d2), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    exp_t e, g;
    rst = v.rst; we = v.we; ws = v.ws; wd = v.wd; r1 = v.r1; r2 = v.r2;
    e.chk = v.chk; e.e1 = v.e1; e.e2 = v.e2;
    e.e_err = $isunknown({we, rst, ws, r1, r2});
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    if (g.chk) begin
      check({name, " read1Data"}, d1, g.e1);
      check({name, " read2Data"}, d2, g.e2);
    end
    check({name, " err"}, {15'd0, err}, {15'd0, g.e_err});
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rs, input logic w, input logic [2:0] s, input logic [15:0] x,
                              input logic [2:0] a, input logic [2:0] b, input logic c,
                              input logic [15:0] p, input logic [15:0] q);
    vec_t v;
    v.rst = rs; v.we = w; v.ws = s; v.wd = x; v.r1 = a; v.r2 = b; v.chk = c; v.e1 = p; v.e2 = q;
    return v;
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; ws = '0; wd = '0; r1 = '0; r2 = '0;
    @(posedge clk); #1;
    tbl.push_back(mk(1, 1, 3, 16'hBEEF, 3, 0, 0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 1, 3, 16'hBEEF, 3, 3, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 3, 16'hBEEF, 0, 1, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 3, 16'hBEEF, 2, 3, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 3, 16'hBEEF, 4, 5, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 3, 16'hBEEF, 6, 7, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 2, 16'h1234, 5, 7, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 2, 16'h1234, 2, 5, 1, 16'h1234, 16'h0000));
    tbl.push_back(mk(0, 1, 6, 16'hA5A5, 6, 6, 1, 16'hA5A5, 16'hA5A5));
    tbl.push_back(mk(0, 0, 6, 16'h0000, 6, 6, 1, 16'hA5A5, 16'hA5A5));
    tbl.push_back(mk(0, 1, 1, 16'h0001, 0, 0, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 16'h00FF, 1, 0, 1, 16'h00FF, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 1, 0, 1, 16'h00FF, 16'h0000));
    tbl.push_back(mk(0, 1, 4, 16'h0040, 4, 2, 1, 16'h0040, 16'h1234));
    tbl.push_back(mk(0, 0, 4, 16'hFFFF, 4, 4, 1, 16'h0040, 16'h0040));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 4, 6, 1, 16'h0040, 16'hA5A5));
    tbl.push_back(mk(0, 1, 7, 16'h7777, 7, 3, 1, 16'h7777, 16'h0000));
    tbl.push_back(mk(0, 0, 7, 16'h0000, 7, 1, 1, 16'h7777, 16'h00FF));
    tbl.push_back(mk(0, 1, 5, 16'h1111, 5, 5, 1, 16'h1111, 16'h1111));
    tbl.push_back(mk(0, 1, 5, 16'h2222, 5, 2, 1, 16'h2222, 16'h1234));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 5, 0, 1, 16'h2222, 16'h0000));
    tbl.push_back(mk(1, 1, 5, 16'h3333, 5, 7, 1, 16'h2222, 16'h7777));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 5, 7, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 2, 4, 1, 16'h0000, 16'h0000));
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // randomised traffic against a reference array, which matches the all-zero state above
    foreach (mem[i]) mem[i] = '0;
    for (int k = 0; k < 200; k++) begin
      vec_t v;
      v = mk($urandom_range(0, 15) == 0, $urandom_range(0, 1), 3'($urandom), 16'($urandom),
             3'($urandom), 3'($urandom), 1, 16'h0, 16'h0);
      v.e1 = (v.we && !v.rst && v.r1 == v.ws) ? v.wd : mem[v.r1];
      v.e2 = (v.we && !v.rst && v.r2 == v.ws) ? v.wd : mem[v.r2];
      step(v, $sformatf("rnd%0d", k));
      if (v.rst) foreach (mem[i]) mem[i] = '0;
      else if (v.we) mem[v.ws] = v.wd;
    end

    rst = 1'b0; we = 1'b0; ws = 3'd0; r1 = 3'd0;
    r2 = 3'bx1x;
    #1;
    check("err with unknown read2RegSel", {15'd0, err}, {15'd0, $isunknown(r2)});
    r2 = 3'd2;
    #1;
    check("err after restore", {15'd0, err}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- Register file: R registers of N bits each, with two asynchronous read ports and one synchronous write port.
- Adds write-to-read bypass. A read of the register being written in the same cycle returns the incoming writeData, not the stale stored value.
- Sits in the decode stage and feeds operands to execute. Writeback drives the write port.
- Removes the need for a separate same-cycle forwarding path into decode.

Parameters:
N, 16, data width in bits per register
R, 8, number of registers (power of two)
SEL_W, 3, register-select width, log2(R)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
read1RegSel  input  SEL_W  register index for read port 1
read2RegSel  input  SEL_W  register index for read port 2
writeRegSel  input  SEL_W  register index for write port
writeData  input  N  data to write
writeEn  input  1  write enable
read1Data  output  N  read port 1 data
read2Data  output  N  read port 2 data
err  output  1  high when any control input is X/Z

Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.

Behaviour:
- Storage: R registers, each N bits. No hard-wired zero register; register 0 is an ordinary register.
- Reset:
  - rst sampled high at a rising edge clears all registers to 0.
  - rst has priority over writeEn: no write occurs in that cycle.
- Write: when rst=0 and writeEn=1 at a rising edge, register[writeRegSel] <= writeData. All other registers hold.
- Read, combinational, zero latency.
  - Stored path: readKData = register[readKRegSel], for K = 1, 2.
  - Bypass condition: writeEn=1 AND rst=0 AND readKRegSel==writeRegSel.
  - When the bypass condition holds, readKData = writeData in the same cycle, before the edge.
  - Bypass is evaluated independently per port. Both ports may bypass at once.
  - Bypass is disabled while rst=1. Reads during reset return stored contents, never data that will not be stored.
- After the write edge, the stored value equals the value bypassed in the previous cycle. The output is therefore glitch-free in value across the edge when the inputs hold.
- err:
  - Combinational, for simulation checking only.
  - 1 if writeEn, rst, writeRegSel, read1RegSel or read2RegSel contains X/Z; otherwise 0.
  - writeData is not checked.
  - err = 0 during and after reset when all inputs are known.
- Output values:
  - read1Data and read2Data hold no reset value of their own. They reflect stored contents, which are all 0 after reset.
  - err follows its inputs and has no reset dependence.
- Boundaries:
  - writeRegSel = R-1 and read select = R-1: bypass applies exactly as for any other index.
  - writeEn=0 with selects equal: no bypass, stored value returned.
  - Back-to-back writes to the same register: each cycle bypasses the new writeData, and the last write wins.
  - rst asserted mid-sequence: the pending write that cycle is dropped and every register reads 0 from the next cycle.

Decomposition:
- Shared package holds constants N, R and SEL_W, plus the derived bypass select encoding.
  - BYP_STORED = 0.
  - BYP_WRITE = 1.
- One sub-module, rf_core: the un-bypassed register file.
  - Contents: R N-bit enabled registers, write decoder and two read muxes, with synchronous reset.
- regfile_bypass instantiates rf_core and adds:
  - the two comparators,
  - the bypass muxes,
  - the err logic.

Test Plan:
- Reset: rst=1 for 2 cycles with writeEn=1, writeRegSel=3, writeData=16'hBEEF. Required: all 8 registers read 16'h0000 afterwards, and during rst read1Data of reg 3 = 16'h0000 (no bypass).
- Basic write/read: write 16'h1234 to reg 2. Next cycle, with writeEn=0, read1RegSel=2 and read2RegSel=5. Required: read1Data=16'h1234, read2Data=16'h0000.
- Bypass both ports: writeEn=1, writeRegSel=6, writeData=16'hA5A5, read1RegSel=read2RegSel=6. Required: both outputs = 16'hA5A5 in the same cycle, before the edge. After the edge with writeEn=0, both still = 16'hA5A5.
- Single-port bypass: reg 1 holds 16'h0001. Write 16'h00FF to reg 1 with read1RegSel=1, read2RegSel=0. Required: read1Data=16'h00FF (bypass), read2Data = stored reg 0 value.
- No bypass when disabled: writeEn=0, writeRegSel=4, writeData=16'hFFFF, read1RegSel=4, reg 4 = 16'h0040. Required: read1Data=16'h0040, and reg 4 is unchanged after the edge.
- Error flag: drive read2RegSel=3'bx1x. Required: err=1. Restore known values. Required: err=0 in the same cycle.
